// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Shared storage for the UART transmit and receive FIFOs.
module uart_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; the owning FIFO's count decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU write path and the UART transmitter.
// Full/empty come from count; all outputs derive from registered state only.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         enq_data,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  output logic [WIDTH-1:0]         deq_data,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             enq_fire;
  logic             deq_fire;

  assign enq_ready = (count_q != CNT_W'(DEPTH));
  assign deq_valid = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;

  // Gated by enq_ready alone, so a same-cycle dequeue never lets a full FIFO accept.
  assign enq_fire = enq_valid && enq_ready;
  assign deq_fire = deq_valid && deq_ready;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (enq_fire),
    .wr_addr (wr_ptr),
    .wr_data (enq_data),
    .rd_addr (rd_ptr),
    .rd_data (deq_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (enq_fire && !deq_fire) begin
        count_q <= count_q + 1'b1;
      end else if (deq_fire && !enq_fire) begin
        count_q <= count_q - 1'b1;
      end
      // Clear wins over a same-cycle attempted write while full.
      if (overflow_clr) begin
        overflow_q <= 1'b0;
      end else if (enq_valid && !enq_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer sitting directly upstream of the UART transmitter.
- Accepts bytes from the CPU memory-mapped I/O write path, stores up to DEPTH of them, and presents them one at a time on a ready/valid interface. That interface drives the transmitter's data_in / data_in_valid / data_in_ready.
- Decouples CPU store bursts from the slow serial line and reports occupancy and overflow for a status register.

Parameters:
- DEPTH, 8: number of byte entries; power of two, at least 2.
- WIDTH, 8: data width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low; state clears on a rising clk edge while reset==0.
- enq_data  input  WIDTH  byte from the CPU write path.
- enq_valid  input  1  enq_data is valid this cycle.
- enq_ready  output  1  FIFO can accept a byte; high iff count<DEPTH.
- deq_data  output  WIDTH  oldest stored byte; connects to the transmitter's data_in.
- deq_valid  output  1  deq_data is valid; high iff count>0; connects to data_in_valid.
- deq_ready  input  1  consumer takes the byte this cycle; connects to data_in_ready.
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a write is attempted while full.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset (reset==0 at a clk edge):
  - read pointer, write pointer and count go to 0; overflow goes to 0.
  - Therefore enq_ready=1, deq_valid=0, count=0.
  - Memory contents are not cleared; deq_data is don't-care while deq_valid=0.
  - Reset mid-operation discards all stored bytes, with no partial dequeue.
- Enqueue fires when enq_valid && enq_ready: write enq_data at the write pointer, then advance the write pointer modulo DEPTH.
- Dequeue fires when deq_valid && deq_ready: advance the read pointer modulo DEPTH.
- Outputs are derived from registered state only. No combinational path from enq_* to deq_*, or from deq_ready to enq_ready.
- Latency:
  - a byte enqueued into an empty FIFO at edge N is visible with deq_valid=1 after edge N; 1-cycle fall-through, no bypass.
  - deq_data is the entry at the read pointer, read asynchronously from a register array.
- count update per edge:
  - enqueue only: +1.
  - dequeue only: -1.
  - both or neither: unchanged.
- Full (count==DEPTH):
  - enq_ready=0; enq_valid is ignored for storage, even if a dequeue fires the same cycle (no write-through when full).
  - enq_valid=1 while full sets overflow; the byte is dropped.
- Empty (count==0):
  - deq_valid=0; deq_ready is ignored.
  - A simultaneous enq_valid enqueues normally.
- Simultaneous enqueue and dequeue with 0<count<DEPTH: both fire, count holds, pointers advance independently.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally. Full/empty come from count, not from a pointer comparison.
- overflow priority:
  - overflow_clr==1 forces overflow to 0, taking priority over a same-cycle set.
  - Otherwise overflow stays set until reset.
- No state machine beyond pointers and count. The consumer's handshake (data_in_ready low while a byte shifts out) throttles dequeue to one byte per frame.

Decomposition:
- Use the shared util.vh log2 macro for pointer and count widths; no new package.
- One natural sub-module: uart_fifo_mem, a DEPTH x WIDTH register array with synchronous write and asynchronous read.
  - The same sub-module is reusable by a future receive-side FIFO behind the UART receiver.
  - Control (pointers, count, overflow) stays in uart_tx_fifo.

Test Plan:
1. Reset then idle: hold reset=0 for 2 cycles, release -> count=0, enq_ready=1, deq_valid=0, overflow=0.
2. Single byte: enqueue 8'h41 with deq_ready=0 -> next cycle deq_valid=1, deq_data=8'h41, count=1; assert deq_ready for 1 cycle -> deq_valid=0, count=0.
3. Fill and overflow: enqueue 8'h00..8'h07 back-to-back, then present 8'hFF -> enq_ready=0 after the 8th write, count=8, overflow=1, 8'hFF never appears; drain -> bytes 00..07 in order.
4. Wrap with simultaneous traffic: preload 5 bytes, then 12 cycles with enq_valid=1 and deq_ready=1 using incrementing data -> count stays 5 throughout, output order strictly matches input order across pointer wrap.
5. Transmitter hookup: connect to uart_transmitter (CLOCK_FREQ=125_000_000, BAUD_RATE=115_200) and enqueue "HI" -> serial line carries 0x48 then 0x49 as 8N1 frames; second dequeue only after the first frame completes.
6. Reset mid-operation, plus overflow_clr priority:
   - with count=3, pull reset=0 for 1 cycle -> count=0, deq_valid=0, no byte emitted.
   - with the FIFO full, drive overflow_clr=1 and enq_valid=1 in the same cycle -> overflow=0.
